// File: rtl/sonar_ranger_if.sv
// Purpose: groups the sonar ranger ping-request, echo input and result signals.
// Ports: start/echo are driven by the processor side and the sonar pin; trig, busy, valid, timeout, echo_cycles are returned.
// Modports: master = processor/testbench side, slave = ranger core.
interface sonar_ranger_if;
  logic        start;
  logic        echo;
  logic        trig;
  logic        busy;
  logic        valid;
  logic        timeout;
  logic [31:0] echo_cycles;

  modport master (
    output start,
    output echo,
    input  trig,
    input  busy,
    input  valid,
    input  timeout,
    input  echo_cycles
  );

  modport slave (
    input  start,
    input  echo,
    output trig,
    output busy,
    output valid,
    output timeout,
    output echo_cycles
  );
endinterface

// File: rtl/sonar_ranger.sv
// Purpose: ultrasonic ranger controller; fires a trigger pulse, measures the echo width in clock cycles.
// Latency: trig rises 1 cycle after start; result 1 cycle after echo falls (plus 2-flop echo sync); no backpressure, start ignored while busy.
// Ports: CLK100MHZ, CPU_RESETN (sync, active-low), bus = sonar_ranger_if.slave (start/echo in, trig/busy/valid/timeout/echo_cycles out).
module sonar_ranger #(
  parameter logic [31:0] TRIG_CYCLES    = 32'd1000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000,
  parameter logic [31:0] HOLDOFF_CYCLES = 32'd6000000
) (
  input  logic           CLK100MHZ,
  input  logic           CPU_RESETN,
  sonar_ranger_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_timeout;
  logic        w_timeout_nxt;
  logic [31:0] r_echo_cycles;
  logic [31:0] w_echo_cycles_nxt;

  // echo is asynchronous to the core clock: r_echo_m is the metastability
  // stage, r_echo_s the usable copy, r_echo_prev its one-cycle history.
  logic        r_echo_m;
  logic        r_echo_s;
  logic        r_echo_prev;
  logic        w_rise;

  assign w_rise = r_echo_s & ~r_echo_prev;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_state       <= IDLE;
      r_cnt         <= 32'd0;
      r_valid       <= 1'b0;
      r_timeout     <= 1'b0;
      r_echo_cycles <= 32'd0;
      r_echo_m      <= 1'b0;
      r_echo_s      <= 1'b0;
      r_echo_prev   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_valid       <= w_valid_nxt;
      r_timeout     <= w_timeout_nxt;
      r_echo_cycles <= w_echo_cycles_nxt;
      r_echo_m      <= bus.echo;
      r_echo_s      <= r_echo_m;
      r_echo_prev   <= r_echo_s;
    end
  end

  // One shared counter: trigger length, echo wait, echo width and holdoff
  // are never timed at the same time.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_valid_nxt       = 1'b0;
    w_timeout_nxt     = r_timeout;
    w_echo_cycles_nxt = r_echo_cycles;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = TRIG;
          w_cnt_nxt   = 32'd0;
        end
      end

      TRIG: begin
        if (r_cnt == TRIG_CYCLES - 32'd1) begin
          w_state_nxt = WAIT_RISE;
          w_cnt_nxt   = 32'd0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      WAIT_RISE: begin
        // A rise seen in the last allowed wait cycle still counts.
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = 32'd1;
        end else if (r_cnt == TIMEOUT_CYCLES - 32'd1) begin
          w_state_nxt       = HOLDOFF;
          w_cnt_nxt         = 32'd0;
          w_valid_nxt       = 1'b1;
          w_timeout_nxt     = 1'b1;
          w_echo_cycles_nxt = TIMEOUT_CYCLES;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      MEASURE: begin
        // Falling edge is tested first so a fall on the limit cycle
        // reports a normal width of TIMEOUT_CYCLES.
        if (!r_echo_s) begin
          w_state_nxt       = HOLDOFF;
          w_cnt_nxt         = 32'd0;
          w_valid_nxt       = 1'b1;
          w_timeout_nxt     = 1'b0;
          w_echo_cycles_nxt = r_cnt;
        end else if (r_cnt == TIMEOUT_CYCLES) begin
          w_state_nxt       = HOLDOFF;
          w_cnt_nxt         = 32'd0;
          w_valid_nxt       = 1'b1;
          w_timeout_nxt     = 1'b1;
          w_echo_cycles_nxt = TIMEOUT_CYCLES;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      HOLDOFF: begin
        if (r_cnt == HOLDOFF_CYCLES - 32'd1) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 32'd0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 32'd0;
      end
    endcase
  end

  // trig decodes straight from the state register so a reset drops it on
  // the same edge that returns the FSM to IDLE.
  assign bus.trig        = (r_state == TRIG);
  assign bus.busy        = (r_state != IDLE);
  assign bus.valid       = r_valid;
  assign bus.timeout     = r_timeout;
  assign bus.echo_cycles = r_echo_cycles;

endmodule

// File: tb/tb_sonar_ranger.sv
module tb_sonar_ranger;
  localparam int TRIG = 10;
  localparam int TMO  = 100;
  localparam int HOLD = 20;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  sonar_ranger_if bus();

  sonar_ranger #(
    .TRIG_CYCLES   (32'd10),
    .TIMEOUT_CYCLES(32'd100),
    .HOLDOFF_CYCLES(32'd20)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rstn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] cycles;
    logic        tmo;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: the ranger reports the number of cycles the echo line was
  // high, capped at TMO, unless the echo never rises (as seen after the
  // two-cycle synchronizer) within TMO cycles of the trigger ending.
  function automatic exp_t model(input int d, input int w, input bit pre);
    exp_t e;
    if (pre || w == 0 || d + 2 >= TMO) begin
      e.cycles = TMO; e.tmo = 1'b1;
    end else if (w > TMO) begin
      e.cycles = TMO; e.tmo = 1'b1;
    end else begin
      e.cycles = w; e.tmo = 1'b0;
    end
    return e;
  endfunction

  // Monitor: result scoreboard, trigger width, holdoff length.
  logic prev_valid = 1'b0;
  logic prev_trig  = 1'b0;
  logic prev_busy  = 1'b0;
  int   trig_len   = 0;
  int   t_valid    = 0;
  int   t_w0       = 0;
  bit   vld_pending = 1'b0;

  always @(negedge clk) begin
    if (bus.valid) begin
      chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got valid=1 with echo_cycles=%0d, required no result", bus.echo_cycles);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("echo_cycles", bus.echo_cycles, e.cycles);
        chk("timeout_flag", {31'd0, bus.timeout}, {31'd0, e.tmo});
      end
      t_valid     = cyc;
      vld_pending = 1'b1;
    end
    if (bus.trig) trig_len++;
    else if (prev_trig) begin
      chk("trig_width", trig_len, TRIG);
      trig_len = 0;
    end
    if (prev_busy && !bus.busy && vld_pending) begin
      chk("holdoff_len", cyc - t_valid, HOLD);
      vld_pending = 1'b0;
    end
    prev_valid = bus.valid;
    prev_trig  = bus.trig;
    prev_busy  = bus.busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One ping: d cycles of quiet after trig falls, then w cycles of echo
  // (w=0: no echo). pre holds echo high from before the start. extra
  // fires stray start pulses in TRIG, MEASURE and HOLDOFF.
  task automatic ping(input int d, input int w, input bit pre, input bit extra);
    int n;
    if (pre) begin
      bus.echo = 1'b1;
      repeat (3) step();
    end
    sb.push_back(model(d, w, pre));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("trig_after_start", {31'd0, bus.trig}, 32'd1);
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (bus.trig && n < 50) begin
      bus.start = extra && (n == 2);
      step();
      n++;
    end
    bus.start = 1'b0;
    chk("trig_fall_seen", {31'd0, bus.trig}, 32'd0);
    t_w0 = cyc;
    repeat (d) step();
    if (pre) begin
      repeat (150) step();
      bus.echo = 1'b0;
    end else if (w > 0) begin
      bus.echo = 1'b1;
      for (int i = 0; i < w; i++) begin
        bus.start = extra && (i == 3);
        step();
      end
      bus.start = 1'b0;
      bus.echo  = 1'b0;
    end
    n = 0;
    while (bus.busy && n < 400) begin
      bus.start = extra && (n == 2);
      step();
      n++;
    end
    bus.start = 1'b0;
    chk("ping_done", {31'd0, bus.busy}, 32'd0);
    repeat (3) step();
    chk("idle_stays", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.echo  = 1'b0;
    rstn      = 1'b0;
    repeat (3) step();
    chk("rst_trig",        {31'd0, bus.trig},    32'd0);
    chk("rst_busy",        {31'd0, bus.busy},    32'd0);
    chk("rst_valid",       {31'd0, bus.valid},   32'd0);
    chk("rst_timeout",     {31'd0, bus.timeout}, 32'd0);
    chk("rst_echo_cycles", bus.echo_cycles,      32'd0);
    rstn = 1'b1;
    repeat (2) step();

    // Nominal 37-cycle echo.
    ping(5, 37, 1'b0, 1'b0);
    // No echo at all: timeout counted from WAIT_RISE entry.
    ping(0, 0, 1'b0, 1'b0);
    chk("wait_timeout_latency", t_valid - t_w0, TMO);
    // Echo stuck high from before the start.
    ping(0, 0, 1'b1, 1'b0);
    // Width limit: falling on the limit wins, one more cycle times out.
    ping(3, 100, 1'b0, 1'b0);
    ping(3, 101, 1'b0, 1'b0);
    // Stray starts while busy.
    ping(10, 20, 1'b0, 1'b1);

    // Reset in the middle of a measurement.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 50 && bus.trig; i++) step();
    bus.echo = 1'b1;
    repeat (20) step();
    rstn = 1'b0;
    step();
    chk("midrst_trig",        {31'd0, bus.trig},  32'd0);
    chk("midrst_busy",        {31'd0, bus.busy},  32'd0);
    chk("midrst_valid",       {31'd0, bus.valid}, 32'd0);
    chk("midrst_echo_cycles", bus.echo_cycles,    32'd0);
    // Start during reset is ignored.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    rstn      = 1'b1;
    bus.echo  = 1'b0;
    step();
    chk("start_in_reset_ignored", {31'd0, bus.busy}, 32'd0);
    repeat (5) step();
    ping(4, 12, 1'b0, 1'b0);

    // Randomized pings.
    for (int k = 0; k < 15; k++) begin
      int d, w, sel;
      d   = $urandom_range(0, 60);
      sel = $urandom_range(0, 9);
      if (sel == 0)      w = 0;
      else if (sel == 1) w = $urandom_range(101, 130);
      else               w = $urandom_range(1, 100);
      ping(d, w, 1'b0, ($urandom_range(0, 3) == 0));
    end

    repeat (5) step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
